// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-unit bundle of decode/execute/memory status inputs and pipeline control outputs.
interface pipe_hazard_ctrl_if;
  logic [2:0] id_Rm, id_Rn, id_Sm, id_Sn, ex_Rd, ex_Sd;
  logic id_srcR_valid, id_srcS_valid, ex_memRead, ex_R_regWrite, ex_S_regWrite;
  logic mem_branch_taken, mem_busy;
  logic pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write;
  logic if_id_flush, id_ex_flush, ex_mem_flush;
  logic [1:0] state;
  logic [15:0] stall_cnt;
  logic mem_timeout;
  modport master (
    output id_Rm, id_Rn, id_Sm, id_Sn, ex_Rd, ex_Sd, id_srcR_valid, id_srcS_valid,
           ex_memRead, ex_R_regWrite, ex_S_regWrite, mem_branch_taken, mem_busy,
    input  pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, state, stall_cnt, mem_timeout
  );
  modport slave (
    input  id_Rm, id_Rn, id_Sm, id_Sn, ex_Rd, ex_Sd, id_srcR_valid, id_srcS_valid,
           ex_memRead, ex_R_regWrite, ex_S_regWrite, mem_branch_taken, mem_busy,
    output pc_write, if_id_write, id_ex_write, ex_mem_write, mem_wb_write,
           if_id_flush, id_ex_flush, ex_mem_flush, state, stall_cnt, mem_timeout
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: load-use stall, branch flush and memory-wait freeze control for a 5-stage pipeline.
module pipe_hazard_ctrl #(
  parameter int BR_PENALTY = 1,
  parameter int TIMEOUT = 255
) (
  input logic clk,
  input logic reset,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [1:0] RUN = 2'd0, BRFLUSH = 2'd1, MEMWAIT = 2'd2;
  localparam logic [3:0] BR_LD = BR_PENALTY[3:0];
  localparam logic [7:0] TO_LIM = TIMEOUT[7:0];
  logic [1:0] r_state;
  logic [3:0] r_br_cnt;
  logic [7:0] r_wait_cnt;
  logic [15:0] r_stall_cnt;
  logic r_timeout;
  logic w_hazard, w_frz, w_bf, w_br, w_hz;
  logic [1:0] w_state_nxt;
  logic [7:0] w_wait_nxt;
  assign w_hazard = bus.ex_memRead &&
    ((bus.ex_R_regWrite && bus.id_srcR_valid && (bus.ex_Rd == bus.id_Rm || bus.ex_Rd == bus.id_Rn)) ||
     (bus.ex_S_regWrite && bus.id_srcS_valid && (bus.ex_Sd == bus.id_Sm || bus.ex_Sd == bus.id_Sn)));
  assign w_frz = reset || bus.mem_busy;
  assign w_bf = r_state == BRFLUSH;
  // MEMWAIT without busy falls through to the RUN rules, so branches and hazards are not lost
  assign w_br = !w_bf && bus.mem_branch_taken;
  assign w_hz = !w_bf && !bus.mem_branch_taken && w_hazard;
  assign bus.pc_write = !w_frz && !w_hz;
  assign bus.if_id_write = !w_frz && !w_hz;
  assign bus.id_ex_write = !w_frz;
  assign bus.ex_mem_write = !w_frz;
  assign bus.mem_wb_write = !w_frz;
  assign bus.if_id_flush = !w_frz && (w_bf || w_br);
  assign bus.id_ex_flush = !w_frz && (w_br || w_hz);
  assign bus.ex_mem_flush = !w_frz && w_br;
  assign bus.state = r_state;
  assign bus.stall_cnt = r_stall_cnt;
  assign bus.mem_timeout = r_timeout;
  assign w_state_nxt = bus.mem_busy ? (w_bf ? BRFLUSH : MEMWAIT) :
                       w_bf ? (r_br_cnt <= 4'd1 ? RUN : BRFLUSH) :
                       w_br ? BRFLUSH : RUN;
  assign w_wait_nxt = !bus.mem_busy ? 8'd0 : r_wait_cnt == TO_LIM ? r_wait_cnt : r_wait_cnt + 8'd1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= RUN;
      r_br_cnt <= 4'd0;
      r_wait_cnt <= 8'd0;
      r_stall_cnt <= 16'd0;
      r_timeout <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_br_cnt <= bus.mem_busy ? r_br_cnt : w_br ? BR_LD : w_bf ? r_br_cnt - 4'd1 : r_br_cnt;
      r_wait_cnt <= w_wait_nxt;
      if (bus.mem_busy && w_wait_nxt == TO_LIM) r_timeout <= 1'b1;
      if (!bus.pc_write && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with BR_PENALTY=1, TIMEOUT=8.
module tb_pipe_hazard_ctrl;
  logic clk, reset;
  int ncmp, nfail;
  logic [26:0] exp_q[$];
  string tag_q[$];
  localparam logic [7:0] RUNOK = 8'hF8, FRZ = 8'h00, BR = 8'hFF, HZ = 8'h3A, BF = 8'hFC;
  pipe_hazard_ctrl_if bus ();
  pipe_hazard_ctrl #(.BR_PENALTY(1), .TIMEOUT(8)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic clr();
    bus.id_Rm = 0; bus.id_Rn = 0; bus.id_Sm = 0; bus.id_Sn = 0; bus.ex_Rd = 0; bus.ex_Sd = 0;
    bus.id_srcR_valid = 0; bus.id_srcS_valid = 0; bus.ex_memRead = 0;
    bus.ex_R_regWrite = 0; bus.ex_S_regWrite = 0; bus.mem_branch_taken = 0; bus.mem_busy = 0;
  endtask
  task automatic load_use();
    bus.ex_memRead = 1; bus.ex_R_regWrite = 1; bus.ex_Rd = 3; bus.id_Rn = 3; bus.id_srcR_valid = 1;
  endtask
  task automatic cyc(input string tag, input logic [7:0] o, input logic [1:0] st, input logic [15:0] sc, input logic to);
    logic [26:0] obs, exp;
    string t;
    exp_q.push_back({o, st, sc, to});
    tag_q.push_back(tag);
    #1;
    obs = {bus.pc_write, bus.if_id_write, bus.id_ex_write, bus.ex_mem_write, bus.mem_wb_write,
           bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.state, bus.stall_cnt, bus.mem_timeout};
    exp = exp_q.pop_front();
    t = tag_q.pop_front();
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed ctl=%h state=%0d stall=%h to=%b, expected ctl=%h state=%0d stall=%h to=%b",
             t, obs[26:19], obs[18:17], obs[16:1], obs[0], exp[26:19], exp[18:17], exp[16:1], exp[0]);
    end
    @(negedge clk);
  endtask
  initial begin
    ncmp = 0; nfail = 0;
    reset = 1;
    clr();
    cyc("reset", FRZ, 0, 0, 0);
    reset = 0;
    cyc("first_run", RUNOK, 0, 0, 0);
    load_use();
    cyc("load_use", HZ, 0, 0, 0);
    bus.id_Rn = 4; bus.id_Rm = 2;
    cyc("no_match", RUNOK, 0, 1, 0);
    clr();
    bus.ex_memRead = 1; bus.ex_S_regWrite = 1; bus.ex_Sd = 5; bus.id_Sm = 5; bus.id_srcS_valid = 1;
    cyc("s_hazard", HZ, 0, 1, 0);
    bus.id_srcS_valid = 0;
    cyc("s_invalid", RUNOK, 0, 2, 0);
    bus.id_srcS_valid = 1; bus.ex_memRead = 0;
    cyc("no_load", RUNOK, 0, 2, 0);
    clr();
    bus.mem_branch_taken = 1;
    cyc("branch", BR, 0, 2, 0);
    cyc("brflush", BF, 1, 2, 0);
    bus.mem_branch_taken = 0;
    cyc("br_done", RUNOK, 0, 2, 0);
    bus.mem_busy = 1;
    for (int i = 0; i < 4; i++) cyc("busy4", FRZ, i == 0 ? 2'd0 : 2'd2, 16'(2 + i), 0);
    bus.mem_busy = 0;
    load_use();
    cyc("memwait_hz", HZ, 2, 6, 0);
    clr();
    cyc("after_hz", RUNOK, 0, 7, 0);
    bus.mem_busy = 1;
    for (int i = 0; i < 8; i++) cyc("busy_to", FRZ, i == 0 ? 2'd0 : 2'd2, 16'(7 + i), 0);
    bus.mem_busy = 0;
    cyc("timeout_set", RUNOK, 2, 15, 1);
    cyc("timeout_sticky", RUNOK, 0, 15, 1);
    bus.mem_busy = 1; bus.mem_branch_taken = 1;
    load_use();
    cyc("prio_busy", FRZ, 0, 15, 1);
    bus.mem_busy = 0;
    cyc("prio_branch", BR, 2, 16, 1);
    clr();
    cyc("prio_brflush", BF, 1, 16, 1);
    cyc("prio_run", RUNOK, 0, 16, 1);
    bus.mem_branch_taken = 1;
    cyc("br2", BR, 0, 16, 1);
    bus.mem_branch_taken = 0; bus.mem_busy = 1;
    cyc("brf_busy", FRZ, 1, 16, 1);
    bus.mem_busy = 0;
    cyc("brf_resume", BF, 1, 17, 1);
    cyc("brf_exit", RUNOK, 0, 17, 1);
    bus.mem_branch_taken = 1;
    cyc("br3", BR, 0, 17, 1);
    clr();
    reset = 1;
    cyc("reset_mid_brf", FRZ, 0, 0, 0);
    reset = 0;
    cyc("post_reset", RUNOK, 0, 0, 0);
    bus.mem_busy = 1;
    repeat (70000) @(negedge clk);
    bus.mem_busy = 0;
    cyc("saturate", RUNOK, 2, 16'hFFFF, 1);
    load_use();
    cyc("sat_hold", HZ, 0, 16'hFFFF, 1);
    clr();
    cyc("sat_final", RUNOK, 0, 16'hFFFF, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
